// File: rtl/seq_div_if.sv
// Operand/result handshake bundle for the sequential divider.
// master drives operands and result acceptance; slave is the divider side.
interface seq_div_if #(
    parameter int DWIDTH = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] dividend;
    logic [DWIDTH-1:0] divisor;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] quotient;
    logic [DWIDTH-1:0] remainder;
    logic              div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle, MSB first.
// Zero divisor short-circuits to DONE with quotient all ones and remainder = dividend.
module seq_div #(
    parameter int DWIDTH = 24
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_div_if.slave  bus
);
    localparam int CW = $clog2(DWIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH:0]   rem_q, rem_d;
    logic [DWIDTH-1:0] dvd_q, dvd_d;
    logic [DWIDTH-1:0] dsr_q, dsr_d;
    logic [DWIDTH-1:0] quot_q, quot_d;
    logic              dbz_q, dbz_d;

    // One guard bit above the partial remainder makes the trial sign explicit.
    logic [DWIDTH+1:0] shifted;
    logic [DWIDTH+1:0] trial;

    assign shifted = {rem_q, dvd_q[DWIDTH-1]};
    assign trial   = shifted - {2'b00, dsr_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quot_d  = quot_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    dvd_d = bus.dividend;
                    dsr_d = bus.divisor;
                    if (bus.divisor == '0) begin
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = {1'b0, bus.dividend};
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                        cnt_d   = CW'(DWIDTH - 1);
                        rem_d   = '0;
                        quot_d  = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end
            ST_CALC: begin
                dvd_d = dvd_q << 1;
                if (!trial[DWIDTH+1]) begin
                    rem_d  = trial[DWIDTH:0];
                    quot_d = {quot_q[DWIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = shifted[DWIDTH:0];
                    quot_d = {quot_q[DWIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quot_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quot_q  <= quot_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.out_valid   = (state_q == ST_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q[DWIDTH-1:0];
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div at DWIDTH=8: directed vector table, backpressure and reset
// sequences, then random operands checked through a result scoreboard.
module tb_seq_div;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_div_if #(.DWIDTH(DW)) bus ();
    seq_div #(.DWIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dbz;
    } res_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dbz;
    } vec_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic res_t mk(input logic [DW-1:0] q, input logic [DW-1:0] r, input logic dbz);
        res_t t;
        t.q = q; t.r = r; t.dbz = dbz;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present operands at a negedge; they are accepted on the next rising edge.
    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input res_t e);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_issue", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = DW'($urandom);
        bus.divisor  = DW'($urandom);
    endtask

    // Called #1 after the accepting edge; lat counts edges until out_valid shows.
    task automatic collect(input int hold, input int exp_lat, input logic poke);
        int   lat;
        res_t e;
        res_t got;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("scoreboard_depth", exp_q.size(), 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : mk('0, '0, 1'b0);
        got = mk(bus.quotient, bus.remainder, bus.div_by_zero);
        chk("quotient", got.q, e.q);
        chk("remainder", got.r, e.r);
        chk("div_by_zero", got.dbz, e.dbz);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.dividend = DW'($urandom);
                bus.divisor  = DW'($urandom);
            end
            @(posedge clk);
            #1;
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_quotient", bus.quotient, got.q);
            chk("hold_remainder", bus.remainder, got.r);
            chk("hold_div_by_zero", bus.div_by_zero, got.dbz);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("consumed_out_valid", bus.out_valid, 0);
        chk("consumed_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        vec_t          vt[10];
        int            stale;
        logic [DW-1:0] ra, rb;
        int            rh;
        logic          rp;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        vt[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  dbz: 1'b0};
        vt[1] = '{a: 8'd5,   b: 8'd0,   q: 8'hFF,  r: 8'd5,  dbz: 1'b1};
        vt[2] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  dbz: 1'b0};
        vt[3] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dbz: 1'b0};
        vt[4] = '{a: 8'd3,   b: 8'd255, q: 8'd0,   r: 8'd3,  dbz: 1'b0};
        vt[5] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dbz: 1'b0};
        vt[6] = '{a: 8'd254, b: 8'd16,  q: 8'd15,  r: 8'd14, dbz: 1'b0};
        vt[7] = '{a: 8'd1,   b: 8'd2,   q: 8'd0,   r: 8'd1,  dbz: 1'b0};
        vt[8] = '{a: 8'd0,   b: 8'd0,   q: 8'hFF,  r: 8'd0,  dbz: 1'b1};
        vt[9] = '{a: 8'd17,  b: 8'd17,  q: 8'd1,   r: 8'd0,  dbz: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_quotient", bus.quotient, 0);
        chk("reset_remainder", bus.remainder, 0);
        chk("reset_div_by_zero", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            issue(vt[i].a, vt[i].b, mk(vt[i].q, vt[i].r, vt[i].dbz));
            collect(i % 3, (vt[i].b == '0) ? 0 : DW, 1'b0);
            $display("vector %0d: %0d / %0d -> expect q=%0d r=%0d dbz=%0d",
                     i, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dbz);
        end

        // Backpressure: out_ready low 5 cycles while new operands are offered.
        issue(8'd91, 8'd6, mk(8'd15, 8'd1, 1'b0));
        collect(5, DW, 1'b1);
        $display("backpressure: 91 / 6 held 5 cycles with in_valid poked");

        // Reset during the fourth CALC step must drop the operation entirely.
        issue(8'd77, 8'd5, mk(8'd15, 8'd2, 1'b0));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_quotient", bus.quotient, 0);
        chk("abort_remainder", bus.remainder, 0);
        chk("abort_div_by_zero", bus.div_by_zero, 0);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stale++;
        end
        chk("no_stale_result", stale, 0);
        issue(8'd100, 8'd10, mk(8'd10, 8'd0, 1'b0));
        collect(0, DW, 1'b0);
        $display("reset abort: 77 / 5 dropped, then 100 / 10");

        for (int n = 0; n < 4000; n++) begin
            ra = DW'($urandom);
            rb = DW'($urandom_range(1, (1 << DW) - 1));
            rh = $urandom_range(0, 3);
            rp = 1'($urandom_range(0, 1));
            issue(ra, rb, mk(ra / rb, ra % rb, 1'b0));
            collect(rh, DW, rp);
            $display("random %0d: %0d / %0d -> q=%0d r=%0d hold=%0d",
                     n, ra, rb, ra / rb, ra % rb, rh);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
